// File: rtl/attn_pkg.sv
// Shared constants and helpers for the attention-layer datapaths.
//   EXP_W / MAN_W : fp16 exponent and mantissa field widths.
//   lzc_cw(w)     : width needed to hold a leading-bit count of 0..w.
//                   Also used by the fp adders to size shift amounts.
package attn_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  function automatic int lzc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lzc_nib4.sv
// Combinational 4-bit leading-zero counter.
//   x_i    : nibble, bit 3 is the most significant
//   cnt_o  : leading zeros 0..3 (reads 3 for an all-zero nibble; the
//            caller qualifies with zero_o)
//   zero_o : nibble is all zeros
module lzc_nib4 (
  input  logic [3:0] x_i,
  output logic [1:0] cnt_o,
  output logic       zero_o
);

  always_comb begin
    cnt_o = 2'd3;
    if      (x_i[3]) cnt_o = 2'd0;
    else if (x_i[2]) cnt_o = 2'd1;
    else if (x_i[1]) cnt_o = 2'd2;
  end

  assign zero_o = (x_i == 4'd0);

endmodule

// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading-zero / leading-one counter with valid/ready.
// Parameters: W (operand width, multiple of 4, 8..64), TAG_W (side-band
// width); CW = lzc_cw(W) is derived.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   in_valid/in_ready            operand handshake
//   in_data, in_mode, in_tag     operand, 0=count zeros / 1=count ones, tag
//   out_valid/out_ready          result handshake
//   out_cnt, out_all, out_tag    count 0..W, all-zeros/ones flag, tag
//   out_norm                     in_data << out_cnt (only with LZC_NORM_EN)
// Optional feature macro: LZC_NORM_EN adds the normalising shifter and the
// out_norm port; without it neither exists.
module lzc_pipe
  import attn_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int TAG_W = 4,
  localparam int CW    = lzc_cw(W)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_cnt,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
`ifdef LZC_NORM_EN
  ,
  output logic [W-1:0]     out_norm
`endif
);

  localparam int NIB = W / 4;

  logic                  s1_v_q, s2_v_q;
  logic                  s1_load, s2_load;
  logic [W-1:0]          x;
  logic [NIB-1:0][1:0]   g_d, g_q;
  logic [NIB-1:0]        z_d, z_q;
  logic [W-1:0]          s1_data_q;
  logic                  s1_mode_q;
  logic [TAG_W-1:0]      s1_tag_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  logic                  all_d, all_q;
  logic [TAG_W-1:0]      tag_q;

  // Flow control: S2 takes S1's operand whenever it is empty or draining;
  // in_ready therefore follows out_ready combinationally.
  assign s2_load  = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = !s1_v_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Leading ones of in_data are leading zeros of its complement.
  assign x = in_mode ? ~in_data : in_data;

  for (genvar k = 0; k < NIB; k++) begin : g_nib
    lzc_nib4 u_nib (
      .x_i    (x[4*k +: 4]),
      .cnt_o  (g_d[k]),
      .zero_o (z_d[k])
    );
  end

  // ---- S1 ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_v_q    <= 1'b0;
      g_q       <= '0;
      z_q       <= '0;
      s1_data_q <= '0;
      s1_mode_q <= 1'b0;
      s1_tag_q  <= '0;
    end else begin
      if (s1_load)      s1_v_q <= 1'b1;
      else if (s2_load) s1_v_q <= 1'b0;
      if (s1_load) begin
        g_q       <= g_d;
        z_q       <= z_d;
        s1_data_q <= in_data;
        s1_mode_q <= in_mode;
        s1_tag_q  <= in_tag;
      end
    end
  end

  // ---- S2 priority combine ----
  // Walk nibbles LSB->MSB so the most significant non-zero nibble is the
  // last to write and wins.
  always_comb begin
    cnt_d = CW'(W);
    all_d = 1'b1;
    for (int k = 0; k < NIB; k++) begin
      if (!z_q[k]) begin
        cnt_d = CW'(4 * (NIB - 1 - k)) + CW'(g_q[k]);
        all_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_v_q <= 1'b0;
      cnt_q  <= '0;
      all_q  <= 1'b0;
      tag_q  <= '0;
    end else begin
      if (s2_load)        s2_v_q <= 1'b1;
      else if (out_ready) s2_v_q <= 1'b0;
      if (s2_load) begin
        cnt_q <= cnt_d;
        all_q <= all_d;
        tag_q <= s1_tag_q;
      end
    end
  end

`ifdef LZC_NORM_EN
  // Shift the original operand (not the complemented one) by the count.
  logic [W-1:0] norm_d, norm_q;

  always_comb begin
    norm_d = all_d ? '0 : (s1_data_q << cnt_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      norm_q <= '0;
    else if (s2_load) norm_q <= norm_d;
  end

  assign out_norm = norm_q;

  // Mode is already folded into the nibble counts.
  logic unused_s1;
  assign unused_s1 = s1_mode_q;
`else
  // S1 data/mode only feed the shifter, which is absent in this build.
  logic unused_s1;
  assign unused_s1 = ^{s1_mode_q, s1_data_q};
`endif

  assign out_valid = s2_v_q;
  assign out_cnt   = cnt_q;
  assign out_all   = all_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_lzc_pipe.sv
module tb_lzc_pipe;
  localparam int W     = 16;
  localparam int TAG_W = 4;
  localparam int CW    = attn_pkg::lzc_cw(W);
  localparam int W2    = 32;
  localparam int CW2   = attn_pkg::lzc_cw(W2);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // W=16 instance
  logic             in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [W-1:0]     in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid, out_all;
  logic [CW-1:0]    out_cnt;
  logic [TAG_W-1:0] out_tag;
  // W=32 instance
  logic             in_valid32 = 1'b0, in_mode32 = 1'b0, out_ready32 = 1'b1;
  logic [W2-1:0]    in_data32 = '0;
  logic [TAG_W-1:0] in_tag32 = '0;
  logic             in_ready32, out_valid32, out_all32;
  logic [CW2-1:0]   out_cnt32;
  logic [TAG_W-1:0] out_tag32;
`ifdef LZC_NORM_EN
  logic [W-1:0]     out_norm;
  logic [W2-1:0]    out_norm32;
`endif

  lzc_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
    .out_all(out_all), .out_tag(out_tag)
`ifdef LZC_NORM_EN
    , .out_norm(out_norm)
`endif
  );

  lzc_pipe #(.W(W2), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .in_mode(in_mode32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_cnt(out_cnt32),
    .out_all(out_all32), .out_tag(out_tag32)
`ifdef LZC_NORM_EN
    , .out_norm(out_norm32)
`endif
  );

  typedef struct {
    int               cnt;
    bit               all;
    logic [TAG_W-1:0] tag;
    logic [63:0]      norm;
    int               acc;   // cycle index of acceptance / latency when seen
  } res_t;

  int   nvec = 0, errs = 0, cyc = 0, front_fs = -1;
  res_t exp_q[$];
  res_t seen[$];

  // Reference: scan the mode-adjusted operand for its highest set bit.
  function automatic res_t model(input logic [63:0] d, input bit m,
                                 input logic [TAG_W-1:0] t, input int w);
    res_t        r;
    logic [63:0] mask, xx;
    mask  = (64'h1 << w) - 64'h1;
    xx    = (m ? ~d : d) & mask;
    r.cnt = w;
    for (int i = 0; i < w; i++) if (xx[i]) r.cnt = w - 1 - i;
    r.all  = (r.cnt == w);
    r.norm = r.all ? 64'h0 : ((d << r.cnt) & mask);
    r.tag  = t;
    r.acc  = 0;
    return r;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    nvec++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Scoreboard bookkeeping on the active edge (pre-update values).
  always @(posedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      front_fs = -1;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        res_t e, s;
        e = exp_q.pop_front();
        s.cnt = int'(out_cnt); s.all = out_all; s.tag = out_tag;
`ifdef LZC_NORM_EN
        s.norm = 64'(out_norm);
`else
        s.norm = 64'h0;
`endif
        s.acc = front_fs - e.acc;
        seen.push_back(s);
        front_fs = -1;
      end
      if (in_valid && in_ready) begin
        res_t e;
        e = model(64'(in_data), in_mode, in_tag, W);
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
    cyc++;
  end

  // Compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      nvec++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL stream16: unexpected result cnt=%0d tag=%0d", out_cnt, out_tag);
      end else begin
        if (front_fs < 0) front_fs = cyc;
        if (out_cnt !== CW'(exp_q[0].cnt) || out_all !== exp_q[0].all ||
            out_tag !== exp_q[0].tag
`ifdef LZC_NORM_EN
            || out_norm !== W'(exp_q[0].norm)
`endif
           ) begin
          errs++;
          $display("FAIL stream16: got cnt=%0d all=%0d tag=%0d, want cnt=%0d all=%0d tag=%0d",
                   out_cnt, out_all, out_tag, exp_q[0].cnt, exp_q[0].all, exp_q[0].tag);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit m, input logic [TAG_W-1:0] t);
    bit r;
    r = 1'b0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
    for (int n = 0; n < 50 && !r; n++) begin
      #1 r = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!r) begin
      nvec++; errs++;
      $display("FAIL send: in_ready never high for tag %0d", t);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_seen(input int i, input string name, input int cnt, input bit all,
                          input int tag, input longint norm, input int lat);
    if (seen.size() <= i) begin
      nvec++; errs++;
      $display("FAIL %s: result %0d missing, got %0d results", name, i, seen.size());
    end else begin
      chk({name, "_cnt"}, seen[i].cnt, cnt);
      chk({name, "_all"}, seen[i].all, all);
      chk({name, "_tag"}, seen[i].tag, tag);
`ifdef LZC_NORM_EN
      chk({name, "_norm"}, seen[i].norm, norm);
`endif
      if (lat >= 0) chk({name, "_lat"}, seen[i].acc, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    logic [W-1:0] pick [4];
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_all", out_all, 0);
    chk("rst_out_tag", out_tag, 0);
`ifdef LZC_NORM_EN
    chk("rst_out_norm", out_norm, 0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Single operands, out_ready high.
    seen.delete();
    send(16'h0000, 1'b0, 4'd1);  drain();
    send(16'h0010, 1'b0, 4'd2);  drain();
    send(16'hFF3A, 1'b1, 4'd3);  drain();
    send(16'hFFFF, 1'b1, 4'd4);  drain();
    chk_seen(0, "zero",  16, 1, 1, 64'h0,    2);
    chk_seen(1, "h0010", 11, 0, 2, 64'h8000, 2);
    chk_seen(2, "hFF3A",  8, 0, 3, 64'h3A00, 2);
    chk_seen(3, "hFFFF", 16, 1, 4, 64'h0,    2);

    // Back-to-back stream.
    seen.delete();
    send(16'h8000, 1'b0, 4'd1);
    send(16'h4000, 1'b0, 4'd2);
    send(16'h0001, 1'b0, 4'd3);
    drain();
    chk_seen(0, "strm0",  0, 0, 1, 64'h8000, 2);
    chk_seen(1, "strm1",  1, 0, 2, 64'h8000, 2);
    chk_seen(2, "strm2", 15, 0, 3, 64'h8000, 2);

    // Back-pressure: two buffered, third stalls until out_ready rises.
    seen.delete();
    out_ready = 1'b0;
    send(16'h0F00, 1'b0, 4'd5);
    send(16'h00F0, 1'b0, 4'd6);
    in_valid = 1'b1; in_data = 16'h000F; in_mode = 1'b0; in_tag = 4'd7;
    #1 chk("bp_in_ready_low", in_ready, 0);
    repeat (2) @(negedge clk);
    #1 chk("bp_in_ready_hold", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_rise", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    chk("bp_count", seen.size(), 3);
    chk_seen(0, "bp0",  4, 0, 5, 64'hF000, -1);
    chk_seen(1, "bp1",  8, 0, 6, 64'hF000, -1);
    chk_seen(2, "bp2", 12, 0, 7, 64'hF000, -1);

    // Mixed traffic with random stalls; checked by the compare process.
    pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h0000; pick[3] = 16'h0000;
    for (int n = 0; n < 80; n++) begin
      pick[2] = 16'($urandom);
      pick[3] = 16'($urandom) >> $urandom_range(0, 16);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = pick[$urandom_range(0, 3)];
      in_mode   = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // W=32 instance.
    in_valid32 = 1'b1; in_data32 = 32'h0000_0100; in_mode32 = 1'b0; in_tag32 = 4'd9;
    #1 chk("w32_in_ready", in_ready32, 1);
    @(negedge clk);
    in_valid32 = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      found = out_valid32;
    end
    chk("w32_valid", found, 1);
    chk("w32_cnt", out_cnt32, 23);
    chk("w32_all", out_all32, 0);
    chk("w32_tag", out_tag32, 9);
    chk("w32_model", out_cnt32, model(64'h100, 1'b0, 4'd9, W2).cnt);
`ifdef LZC_NORM_EN
    chk("w32_norm", out_norm32, 32'h8000_0000);
`endif

    // Reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h1234, 1'b0, 4'd10);
    send(16'h0F00, 1'b0, 4'd11);
    #1 chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    resetn = 1'b0;
    #1 chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    chk("post_rst_w32_idle", out_valid32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
